// File: rtl/alu_pkg.sv
// Shared constants and the issue bundle type for the ALU decode/issue stage.
package alu_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned RF_AW_DEF = 5;

  localparam logic [2:0] ALU_SEL_ADD  = 3'b000;
  localparam logic [2:0] ALU_SEL_SUB  = 3'b001;
  localparam logic [2:0] ALU_SEL_SLL  = 3'b010;
  localparam logic [2:0] ALU_SEL_SUBU = 3'b011;
  localparam logic [2:0] ALU_SEL_SR   = 3'b100;
  localparam logic [2:0] ALU_SEL_XOR  = 3'b101;
  localparam logic [2:0] ALU_SEL_OR   = 3'b110;
  localparam logic [2:0] ALU_SEL_AND  = 3'b111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_sel;
    logic        slt;
    logic [4:0]  rd;
    logic        illegal;
  } issue_bundle_t;

  // Shift operand as the ALU expects it: arithmetic flag in bit 31, amount in [4:0].
  function automatic logic [31:0] shift_b(input logic arith, input logic [4:0] shamt);
    return {arith, 26'b0, shamt};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode: instruction, PC and register data to an ALU issue bundle.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic [31:0]   pc,
  input  logic [31:0]   rs1_data,
  input  logic [31:0]   rs2_data,
  output issue_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [4:0]  shamt;
  logic        is_imm;
  logic        f7_ok;
  logic        legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1_v  = (instr[19:15] == 5'd0) ? 32'd0 : rs1_data;
  assign rs2_v  = (instr[24:20] == 5'd0) ? 32'd0 : rs2_data;
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign is_imm = (opcode == OPC_OP_IMM);
  assign shamt  = is_imm ? instr[24:20] : rs2_v[4:0];
  // Immediate forms carry immediate bits where funct7 would be, except for shifts.
  assign f7_ok  = is_imm || (funct7 == F7_BASE);

  always_comb begin
    bundle = '0;
    legal  = 1'b1;
    unique case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        bundle.a  = rs1_v;
        bundle.b  = is_imm ? imm_i : rs2_v;
        bundle.rd = instr[11:7];
        unique case (funct3)
          F3_ADD: begin
            if (!is_imm && funct7 == F7_ALT) bundle.alu_sel = ALU_SEL_SUB;
            else legal = f7_ok;
          end
          F3_SLL: begin
            bundle.alu_sel = ALU_SEL_SLL;
            bundle.b       = shift_b(1'b0, shamt);
            legal          = (funct7 == F7_BASE);
          end
          F3_SLT: begin
            bundle.alu_sel = ALU_SEL_SUB;
            bundle.slt     = 1'b1;
            legal          = f7_ok;
          end
          F3_SLTU: begin
            bundle.alu_sel = ALU_SEL_SUBU;
            bundle.slt     = 1'b1;
            legal          = f7_ok;
          end
          F3_XOR: begin
            bundle.alu_sel = ALU_SEL_XOR;
            legal          = f7_ok;
          end
          F3_SR: begin
            bundle.alu_sel = ALU_SEL_SR;
            bundle.b       = shift_b(funct7 == F7_ALT, shamt);
            legal          = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          F3_OR: begin
            bundle.alu_sel = ALU_SEL_OR;
            legal          = f7_ok;
          end
          default: begin
            bundle.alu_sel = ALU_SEL_AND;
            legal          = f7_ok;
          end
        endcase
      end
      OPC_LOAD: begin
        bundle.a  = rs1_v;
        bundle.b  = imm_i;
        bundle.rd = instr[11:7];
        legal     = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE: begin
        bundle.a = rs1_v;
        bundle.b = imm_s;
        legal    = funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OPC_BRANCH: begin
        bundle.a       = rs1_v;
        bundle.b       = rs2_v;
        bundle.alu_sel = funct3[1] ? ALU_SEL_SUBU : ALU_SEL_SUB;
        legal          = (funct3[2:1] != 2'b01);
      end
      OPC_LUI: begin
        bundle.b  = imm_u;
        bundle.rd = instr[11:7];
      end
      OPC_AUIPC: begin
        bundle.a  = pc;
        bundle.b  = imm_u;
        bundle.rd = instr[11:7];
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      bundle         = '0;
      bundle.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: decoded bundle into an output register backed by one skid register.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic [RF_AW-1:0] rs1_addr,
  output logic [RF_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [2:0]       out_alu_sel,
  output logic             out_slt,
  output logic [RF_AW-1:0] out_rd,
  output logic             out_illegal
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

  occ_e          state_q, state_d;
  issue_bundle_t out_q, out_d;
  issue_bundle_t skid_q, skid_d;
  issue_bundle_t dec;
  logic          accept;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  alu_issue_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (dec)
  );

  // Both flags depend only on the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      out_d   = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            out_d   = dec;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && !out_ready) begin
            skid_d  = dec;
            state_d = StTwo;
          end else if (accept && out_ready) begin
            out_d = dec;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_ready) begin
            out_d   = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_alu_sel = out_q.alu_sel;
  assign out_slt     = out_q.slt;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed cases then random traffic against a 2-deep queue model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic        in_ready, out_valid, out_slt, out_illegal;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data, out_a, out_b;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [2:0]  out_alu_sel;

  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32), .RF_AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alu_sel (out_alu_sel),
    .out_slt     (out_slt),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic        slt;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode by instruction mnemonic, using the bench's own register file.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic        ok, imm;
    logic [31:0] r1, r2, immi, imms, immu;
    logic [4:0]  sh;
    logic [6:0]  op;
    logic [2:0]  f3;
    op   = ins[6:0];
    f3   = ins[14:12];
    r1   = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
    r2   = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    immu = {ins[31:12], 12'h000};
    imm  = (op == 7'h13);
    sh   = imm ? ins[24:20] : r2[4:0];
    e    = '0;
    ok   = 1'b1;
    case (op)
      7'h33, 7'h13: begin
        e.a  = r1;
        e.rd = ins[11:7];
        e.b  = imm ? immi : r2;
        casez ({imm, ins[31:25], f3})
          11'b0_0000000_000, 11'b1_???????_000: e.sel = 3'd0;
          11'b0_0100000_000: e.sel = 3'd1;
          11'b?_0000000_001: begin e.sel = 3'd2; e.b = {27'd0, sh}; end
          11'b0_0000000_010, 11'b1_???????_010: begin e.sel = 3'd1; e.slt = 1'b1; end
          11'b0_0000000_011, 11'b1_???????_011: begin e.sel = 3'd3; e.slt = 1'b1; end
          11'b0_0000000_100, 11'b1_???????_100: e.sel = 3'd5;
          11'b?_0000000_101: begin e.sel = 3'd4; e.b = {27'd0, sh}; end
          11'b?_0100000_101: begin e.sel = 3'd4; e.b = 32'h8000_0000 + {27'd0, sh}; end
          11'b0_0000000_110, 11'b1_???????_110: e.sel = 3'd6;
          11'b0_0000000_111, 11'b1_???????_111: e.sel = 3'd7;
          default: ok = 1'b0;
        endcase
      end
      7'h03: begin
        e.a = r1; e.b = immi; e.rd = ins[11:7];
        ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      end
      7'h23: begin e.a = r1; e.b = imms; ok = (f3 < 3); end
      7'h63: begin
        e.a = r1; e.b = r2;
        e.sel = (f3 >= 6) ? 3'd3 : 3'd1;
        ok = (f3 != 2) && (f3 != 3);
      end
      7'h37: begin e.b = immu; e.rd = ins[11:7]; end
      7'h17: begin e.a = pc; e.b = immu; e.rd = ins[11:7]; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e     = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  ops [7];
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;
    ops[4] = 7'h63; ops[5] = 7'h37; ops[6] = 7'h17;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      w[6:0] = ops[$urandom_range(0, 6)];
      if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && w[12] == 1'b1))
        if ($urandom_range(0, 4) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      check({tag, "_a"}, out_a, q[0].a);
      check({tag, "_b"}, out_b, q[0].b);
      check({tag, "_sel"}, 32'(out_alu_sel), 32'(q[0].sel));
      check({tag, "_slt"}, 32'(out_slt), 32'(q[0].slt));
      check({tag, "_rd"}, 32'(out_rd), 32'(q[0].rd));
      check({tag, "_illegal"}, 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  // One clock: drive at negedge, predict the queue, compare at the next negedge.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic ordy, input logic fl, input logic r);
    logic        can_push;
    logic [31:0] pc;
    pc        = $urandom & 32'hFFFF_FFFC;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    check({tag, "_rs1_addr"}, 32'(rs1_addr), 32'(ins[19:15]));
    check({tag, "_rs2_addr"}, 32'(rs2_addr), 32'(ins[24:20]));
    if (r || fl) begin
      q.delete();
    end else begin
      can_push = (q.size() < 2);
      if (ordy && q.size() != 0) q.delete(0);
      if (v && can_push) q.push_back(model(ins, pc));
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0]     = 32'hDEAD_BEEF;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    step("reset", 1'b1, 32'hFFF1_0093, 1'b0, 1'b0, 1'b1);
    step("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("rst_a", out_a, 32'h0);
    check("rst_b", out_b, 32'h0);
    check("rst_sel_rd", {24'h0, out_alu_sel, out_rd}, 32'h0);
    check("rst_flags", {30'h0, out_slt, out_illegal}, 32'h0);

    rf[2] = 32'd5;
    step("addi", 1'b1, 32'hFFF1_0093, 1'b1, 1'b0, 1'b0);
    check("t1_a", out_a, 32'd5);
    check("t1_b", out_b, 32'hFFFF_FFFF);
    check("t1_sel", 32'(out_alu_sel), 32'd0);
    check("t1_rd", 32'(out_rd), 32'd1);

    rf[6] = 32'h8000_0000;
    step("srai", 1'b1, 32'h4033_5293, 1'b1, 1'b0, 1'b0);
    check("t2_b", out_b, 32'h8000_0003);
    check("t2_sel", 32'(out_alu_sel), 32'd4);
    check("t2_rd", 32'(out_rd), 32'd5);

    rf[1] = 32'd7;
    rf[3] = 32'd9;
    step("sub", 1'b1, 32'h4030_8133, 1'b1, 1'b0, 1'b0);
    check("t3_a", out_a, 32'd7);
    check("t3_b", out_b, 32'd9);
    check("t3_sel", 32'(out_alu_sel), 32'd1);
    step("bltu", 1'b1, 32'h0030_E063, 1'b1, 1'b0, 1'b0);
    check("t3_bltu_sel", 32'(out_alu_sel), 32'd3);
    step("drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    step("bp", 1'b1, 32'h0011_0193, 1'b0, 1'b0, 1'b0);
    step("bp", 1'b1, 32'h0021_0213, 1'b0, 1'b0, 1'b0);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    step("bp", 1'b1, 32'h0031_0293, 1'b0, 1'b0, 1'b0);
    step("bp", 1'b1, 32'h0041_0313, 1'b0, 1'b0, 1'b0);
    step("bp_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t4_second_b", out_b, 32'd2);
    step("bp_drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t4_empty", 32'(out_valid), 32'd0);

    step("fl", 1'b1, 32'h0011_0193, 1'b0, 1'b0, 1'b0);
    step("fl", 1'b1, 32'h0021_0213, 1'b0, 1'b0, 1'b0);
    step("fl", 1'b1, 32'h0031_0293, 1'b1, 1'b1, 1'b0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    step("fl_after", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t5_nothing", 32'(out_valid), 32'd0);

    step("illegal", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check("t6_illegal", 32'(out_illegal), 32'd1);
    check("t6_sel", 32'(out_alu_sel), 32'd0);
    check("t6_ab", out_a | out_b, 32'd0);
    step("mid", 1'b1, 32'h0011_0193, 1'b0, 1'b0, 1'b0);
    step("mid_rst", 1'b1, 32'h0021_0213, 1'b0, 1'b0, 1'b1);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_a", out_a, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = $urandom;
      step("rand", $urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
    end
    step("final", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step("final", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
